// File: rtl/handshake_pipe_pkg.sv
// Shared constants and helpers for the handshake_pipe delay line.
package handshake_pipe_pkg;

    // Largest stage count the occupancy helper can count.
    localparam int unsigned MAX_DEPTH = 64;

    function automatic int unsigned f_popcount(input logic [MAX_DEPTH-1:0] vec);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n = n + 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/handshake_pipe_stage.sv
// One pipeline slot: a valid bit plus a data register with load enable and flush.
module handshake_pipe_stage
    import handshake_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_valid_nxt,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_data_nxt;

    // Next-state selection: flush wins, bubbles never disturb the data register.
    always_comb begin
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
        end else if (i_load) begin
            w_valid_nxt = i_valid;
            if (i_valid) begin
                w_data_nxt = i_data;
            end else begin
                w_data_nxt = r_data;
            end
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
        end else begin
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;
    assign o_data      = r_data;

endmodule

// File: rtl/handshake_pipe.sv
// Flow-controlled delay line of DEPTH stages with per-stage ready chain,
// bubble collapse, synchronous flush and a registered occupancy count.
module handshake_pipe
    import handshake_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH:0]       w_ready;
    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0]     w_valid_nxt;
    logic [DEPTH-1:0]     w_up_valid;
    logic [WIDTH-1:0]     w_data    [DEPTH];
    logic [WIDTH-1:0]     w_up_data [DEPTH];
    logic [MAX_DEPTH-1:0] w_valid_ext;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [CNT_W-1:0]     r_count;

    // Ready chain from the output back: an empty stage always accepts.
    always_comb begin
        w_ready        = {(DEPTH + 1){1'b0}};
        w_ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_ready[i] = !w_valid[i] || w_ready[i + 1];
        end
    end

    // Each stage is fed by its upstream neighbour, stage 0 by the input port.
    always_comb begin
        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_up_valid[i] = w_valid[i - 1];
            w_up_data[i]  = w_data[i - 1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        handshake_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_flush     (flush),
            .i_load      (w_ready[g]),
            .i_valid     (w_up_valid[g]),
            .i_data      (w_up_data[g]),
            .o_valid     (w_valid[g]),
            .o_valid_nxt (w_valid_nxt[g]),
            .o_data      (w_data[g])
        );
    end

    // Occupancy of the state the stages are about to take (DEPTH <= MAX_DEPTH).
    always_comb begin
        w_valid_ext              = {MAX_DEPTH{1'b0}};
        w_valid_ext[DEPTH-1:0]   = w_valid_nxt;
        w_count_nxt              = CNT_W'(f_popcount(w_valid_ext));
    end

    // Occupancy register, updated on the same edge as the valid bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_valid[DEPTH-1] && !flush;
    assign out_data  = w_data[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_handshake_pipe.sv
// Directed self-checking bench for handshake_pipe (DEPTH=3 and DEPTH=4 instances).
module tb_handshake_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, flush3;
    logic [31:0] in_data3, out_data3;
    logic [1:0]  count3;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, flush4;
    logic [31:0] in_data4, out_data4;
    logic [2:0]  count4;

    int tests = 0;
    int fails = 0;

    int exp_v [7] = '{0, 0, 1, 1, 1, 1, 0};
    int exp_d [7] = '{0, 0, 1, 2, 3, 4, 4};
    int exp_c [7] = '{1, 2, 3, 3, 2, 1, 0};

    handshake_pipe #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .flush(flush3), .count(count3)
    );

    handshake_pipe #(.WIDTH(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .flush(flush4), .count(count4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid3  = 1'b1;
        in_data3   = 32'hDEAD_BEEF;
        out_ready3 = 1'b0;
        flush3     = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = 32'd0;
        out_ready4 = 1'b0;
        flush4     = 1'b0;

        // Reset
        tick;
        tick;
        chk("rst_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("rst_out_data", out_data3, 32'd0);
        chk("rst_count", {30'd0, count3}, 32'd0);
        chk("rst_count4", {29'd0, count4}, 32'd0);
        in_valid3 = 1'b0;
        reset_n   = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready3}, 32'd1);

        // Streaming 1..4 with out_ready high
        out_ready3 = 1'b1;
        for (int s = 0; s < 7; s++) begin
            in_valid3 = (s < 4);
            in_data3  = 32'(s + 1);
            tick;
            chk("stream_valid", {31'd0, out_valid3}, 32'(exp_v[s]));
            chk("stream_data", out_data3, 32'(exp_d[s]));
            chk("stream_count", {30'd0, count3}, 32'(exp_c[s]));
        end

        // Backpressure: 10,11,12 fill the pipe, 13 waits
        out_ready3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid3 = 1'b1;
            in_data3  = 32'(10 + k);
            #1;
            chk("bp_in_ready_fill", {31'd0, in_ready3}, 32'd1);
            tick;
        end
        in_data3 = 32'd13;
        #1;
        chk("bp_in_ready_full", {31'd0, in_ready3}, 32'd0);
        chk("bp_count_full", {30'd0, count3}, 32'd3);
        chk("bp_out_valid", {31'd0, out_valid3}, 32'd1);
        chk("bp_out_data", out_data3, 32'd10);
        tick;
        chk("bp_in_ready_hold", {31'd0, in_ready3}, 32'd0);
        chk("bp_count_hold", {30'd0, count3}, 32'd3);
        out_ready3 = 1'b1;
        #1;
        chk("bp_in_ready_release", {31'd0, in_ready3}, 32'd1);
        tick;
        in_valid3 = 1'b0;
        chk("bp_count_inout", {30'd0, count3}, 32'd3);
        for (int k = 1; k < 4; k++) begin
            chk("bp_drain_valid", {31'd0, out_valid3}, 32'd1);
            chk("bp_drain_data", out_data3, 32'(10 + k));
            tick;
        end
        chk("bp_empty_valid", {31'd0, out_valid3}, 32'd0);
        chk("bp_empty_count", {30'd0, count3}, 32'd0);

        // Flush with three entries held and a new input waiting
        out_ready3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid3 = 1'b1;
            in_data3  = 32'(20 + k);
            tick;
        end
        in_data3 = 32'd23;
        flush3   = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, in_ready3}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("fl_count_pre", {30'd0, count3}, 32'd3);
        tick;
        flush3 = 1'b0;
        #1;
        chk("fl_count_post", {30'd0, count3}, 32'd0);
        chk("fl_out_valid_post", {31'd0, out_valid3}, 32'd0);
        chk("fl_data_held", out_data3, 32'd20);
        chk("fl_in_ready_post", {31'd0, in_ready3}, 32'd1);
        tick;
        in_valid3 = 1'b0;
        chk("fl_accept_count", {30'd0, count3}, 32'd1);
        out_ready3 = 1'b1;
        tick;
        tick;
        chk("fl_emerge_valid", {31'd0, out_valid3}, 32'd1);
        chk("fl_emerge_data", out_data3, 32'd23);
        tick;
        chk("fl_drained", {30'd0, count3}, 32'd0);

        // Bubble collapse on the DEPTH=4 instance
        in_valid4 = 1'b1;
        in_data4  = 32'd5;
        tick;
        in_valid4 = 1'b0;
        tick;
        in_valid4 = 1'b1;
        in_data4  = 32'd6;
        tick;
        in_valid4 = 1'b0;
        tick;
        tick;
        tick;
        chk("bub_count", {29'd0, count4}, 32'd2);
        chk("bub_in_ready", {31'd0, in_ready4}, 32'd1);
        chk("bub_out_valid", {31'd0, out_valid4}, 32'd1);
        chk("bub_out_data", out_data4, 32'd5);
        out_ready4 = 1'b1;
        tick;
        chk("bub_next_data", out_data4, 32'd6);
        chk("bub_next_count", {29'd0, count4}, 32'd1);
        tick;
        chk("bub_empty_valid", {31'd0, out_valid4}, 32'd0);

        // Mid-stream asynchronous reset
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        in_data3   = 32'd30;
        tick;
        in_data3 = 32'd31;
        tick;
        in_valid3 = 1'b0;
        tick;
        chk("mr_count_pre", {30'd0, count3}, 32'd2);
        chk("mr_out_data_pre", out_data3, 32'd30);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("mr_count", {30'd0, count3}, 32'd0);
        chk("mr_out_data", out_data3, 32'd0);
        #1;
        reset_n    = 1'b1;
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        in_data3   = 32'd40;
        tick;
        in_valid3 = 1'b0;
        chk("mr_lat1", {31'd0, out_valid3}, 32'd0);
        tick;
        chk("mr_lat2", {31'd0, out_valid3}, 32'd0);
        tick;
        chk("mr_lat3_valid", {31'd0, out_valid3}, 32'd1);
        chk("mr_lat3_data", out_data3, 32'd40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
